// File: rtl/image_buffer_pkg.sv
// Shared cfg-bus address map and the state encodings used by image_buffer.
package image_buffer_pkg;

  localparam logic [4:0] CFG_IMG_WR_LEN = 5'd6;
  localparam logic [4:0] CFG_IMG_WR     = 5'd7;
  localparam logic [4:0] CFG_IMG_RD_LEN = 5'd8;
  localparam logic [4:0] CFG_IMG_RD     = 5'd9;

  // Output skid FIFO depth; must cover the three-stage read pipeline plus one.
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/image_buffer_bank.sv
// One image bank: wide word-addressed write port, narrow group-addressed
// read port with two registered read stages.
module image_buffer_bank #(
  parameter int IMG_WIDTH  = 16,
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int MEM_AWIDTH = 10,
  localparam int R         = DEPTH_NB / GROUP_NB,
  localparam int SEL_W     = $clog2(R),
  localparam int WA_W      = MEM_AWIDTH - SEL_W,
  localparam int WORD_W    = IMG_WIDTH * DEPTH_NB,
  localparam int GRP_W     = IMG_WIDTH * GROUP_NB
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [WA_W-1:0]       wr_addr,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [MEM_AWIDTH-1:0] rd_addr,
  output logic [GRP_W-1:0]      rd_data
);

  logic [WORD_W-1:0] mem [2**WA_W];
  logic [WORD_W-1:0] word_q;
  logic [SEL_W-1:0]  sel_q;

  // Read and write share one process, so a same-cycle collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      word_q <= mem[rd_addr[MEM_AWIDTH-1:SEL_W]];
      sel_q  <= rd_addr[SEL_W-1:0];
    end
    rd_data <= word_q[sel_q*GRP_W +: GRP_W];
  end

endmodule

// File: rtl/image_buffer.sv
// Ping-pong image store: sequential wide-word write engine, group read engine
// with credit-based skid FIFO. IMAGE_BUFFER_STATUS_EN adds wr_busy/rd_busy outputs.
module image_buffer
  import image_buffer_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int DEPTH_NB   = 16,
  parameter int MEM_AWIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] str_img_bus,
  input  logic                          str_img_val,
  output logic                          str_img_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy
`ifdef IMAGE_BUFFER_STATUS_EN
  ,
  output logic                          wr_busy,
  output logic                          rd_busy
`endif
);

  localparam int R      = DEPTH_NB / GROUP_NB;
  localparam int SEL_W  = $clog2(R);
  localparam int WA_W   = MEM_AWIDTH - SEL_W;
  localparam int GRP_W  = IMG_WIDTH * GROUP_NB;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  wr_state_t wr_state, wr_state_nx;
  rd_state_t rd_state, rd_state_nx;

  logic [CFG_DWIDTH-1:0] wr_len, rd_len;
  logic                  wr_bank, rd_bank;
  logic                  wr_start, rd_start;

  logic [CFG_DWIDTH-1:0] wr_left, rd_left;
  logic [WA_W-1:0]       wr_addr;
  logic [MEM_AWIDTH-1:0] rd_addr;
  logic                  wr_accept, rd_issue;

  logic                  v1, v2, v3;
  logic                  b1, b2;
  logic                  l1, l2, l3;
  logic [GRP_W-1:0]      data3;
  logic [GRP_W-1:0]      rd_data0, rd_data1;

  logic [GRP_W:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      fifo_wp, fifo_rp;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [GRP_W:0]        fifo_head;
  logic                  push, pop;
  logic [3:0]            occ;

  // ---------------- cfg registers ----------------
  assign wr_start = cfg_valid && (cfg_addr == CFG_IMG_WR) &&
                    (wr_state == WR_IDLE) && (wr_len != '0);
  assign rd_start = cfg_valid && (cfg_addr == CFG_IMG_RD) &&
                    (rd_state == RD_IDLE) && (rd_len != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_len  <= '0;
      rd_len  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (cfg_valid && (cfg_addr == CFG_IMG_WR_LEN)) wr_len <= cfg_data;
      if (cfg_valid && (cfg_addr == CFG_IMG_RD_LEN)) rd_len <= cfg_data;
      if (wr_start) wr_bank <= cfg_data[0];
      if (rd_start) rd_bank <= cfg_data[0];
    end
  end

  // ---------------- write engine ----------------
  assign str_img_rdy = (wr_state == WR_WRITE);
  assign wr_accept   = str_img_val && str_img_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_nx;
  end

  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      WR_IDLE:  if (wr_start) wr_state_nx = WR_WRITE;
      WR_WRITE: if (wr_accept && (wr_left == CFG_DWIDTH'(1))) wr_state_nx = WR_IDLE;
      default:  wr_state_nx = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_left <= '0;
      wr_addr <= '0;
    end else if (wr_start) begin
      wr_left <= wr_len;
      wr_addr <= '0;
    end else if (wr_accept) begin
      wr_left <= wr_left - CFG_DWIDTH'(1);
      wr_addr <= wr_addr + WA_W'(1);
    end
  end

  // ---------------- banks ----------------
  image_buffer_bank #(
    .IMG_WIDTH (IMG_WIDTH),
    .DEPTH_NB  (DEPTH_NB),
    .GROUP_NB  (GROUP_NB),
    .MEM_AWIDTH(MEM_AWIDTH)
  ) u_bank0 (
    .clk    (clk),
    .wr_en  (wr_accept && !wr_bank),
    .wr_addr(wr_addr),
    .wr_data(str_img_bus),
    .rd_en  (rd_issue),
    .rd_addr(rd_addr),
    .rd_data(rd_data0)
  );

  image_buffer_bank #(
    .IMG_WIDTH (IMG_WIDTH),
    .DEPTH_NB  (DEPTH_NB),
    .GROUP_NB  (GROUP_NB),
    .MEM_AWIDTH(MEM_AWIDTH)
  ) u_bank1 (
    .clk    (clk),
    .wr_en  (wr_accept && wr_bank),
    .wr_addr(wr_addr),
    .wr_data(str_img_bus),
    .rd_en  (rd_issue),
    .rd_addr(rd_addr),
    .rd_data(rd_data1)
  );

  // ---------------- read engine ----------------
  assign pop = image_val && image_rdy;
  assign occ = 4'(fifo_cnt) + 4'(v1) + 4'(v2) + 4'(v3);
  // Every issued read is guaranteed a FIFO slot, counting a slot freed this cycle.
  assign rd_issue = (rd_state == RD_READ) && (rd_left != '0) &&
                    ((occ - 4'(pop)) < 4'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nx;
  end

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_start) rd_state_nx = RD_READ;
      RD_READ: if (pop && fifo_head[GRP_W]) rd_state_nx = RD_IDLE;
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_left <= '0;
      rd_addr <= '0;
    end else if (rd_start) begin
      rd_left <= rd_len;
      rd_addr <= '0;
    end else if (rd_issue) begin
      rd_left <= rd_left - CFG_DWIDTH'(1);
      rd_addr <= rd_addr + MEM_AWIDTH'(1);
    end
  end

  // Valid/bank/last tags travel alongside the bank read stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      b1 <= 1'b0; b2 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0; l3 <= 1'b0;
    end else begin
      v1 <= rd_issue;
      b1 <= rd_bank;
      l1 <= rd_issue && (rd_left == CFG_DWIDTH'(1));
      v2 <= v1;
      b2 <= b1;
      l2 <= l1;
      v3 <= v2;
      l3 <= l2;
    end
  end

  always_ff @(posedge clk) begin
    if (v2) data3 <= b2 ? rd_data1 : rd_data0;
  end

  // ---------------- output skid FIFO ----------------
  assign push = v3;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= {l3, data3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) fifo_wp <= fifo_wp + PTR_W'(1);
      if (pop)  fifo_rp <= fifo_rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign fifo_head  = fifo_mem[fifo_rp];
  assign image_val  = (fifo_cnt != '0);
  assign image_bus  = image_val ? fifo_head[GRP_W-1:0] : '0;
  assign image_last = image_val && fifo_head[GRP_W];

`ifdef IMAGE_BUFFER_STATUS_EN
  assign wr_busy = (wr_state != WR_IDLE);
  assign rd_busy = (rd_state != RD_IDLE);
`endif

endmodule

// File: tb/tb_image_buffer.sv
// Self-checking bench for image_buffer: pass table plus hand-written
// latency, backpressure, busy-start and reset sequences.
module tb_image_buffer;
  import image_buffer_pkg::*;

  localparam int CFG_DWIDTH  = 32;
  localparam int CFG_AWIDTH  = 5;
  localparam int GROUP_NB    = 4;
  localparam int IMG_WIDTH   = 16;
  localparam int DEPTH_NB    = 16;
  localparam int MEM_AWIDTH  = 10;
  localparam int WORD_W      = IMG_WIDTH * DEPTH_NB;
  localparam int GRP_W       = IMG_WIDTH * GROUP_NB;
  localparam int R           = DEPTH_NB / GROUP_NB;
  localparam int BANK_GROUPS = 1024;
  localparam int BANK_WORDS  = BANK_GROUPS / R;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;
  logic [WORD_W-1:0]     str_img_bus;
  logic                  str_img_val;
  logic                  str_img_rdy;
  logic [GRP_W-1:0]      image_bus;
  logic                  image_last;
  logic                  image_val;
  logic                  image_rdy;
`ifdef IMAGE_BUFFER_STATUS_EN
  logic                  wr_busy;
  logic                  rd_busy;
`endif

  image_buffer #(
    .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .GROUP_NB(GROUP_NB),
    .IMG_WIDTH(IMG_WIDTH), .DEPTH_NB(DEPTH_NB), .MEM_AWIDTH(MEM_AWIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .str_img_bus(str_img_bus), .str_img_val(str_img_val), .str_img_rdy(str_img_rdy),
    .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
    .image_rdy(image_rdy)
`ifdef IMAGE_BUFFER_STATUS_EN
    , .wr_busy(wr_busy), .rd_busy(rd_busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GRP_W-1:0] data;
    logic             last;
  } exp_t;

  typedef struct {
    int wr_bank;
    int wr_len;
    int base;
    int rd_bank;
    int rd_len;
    int rdy_mode;
    int exp_xfers;
  } vec_t;

  exp_t              sb_q[$];
  exp_t              e;
  logic [WORD_W-1:0] model_mem [2][BANK_WORDS];
  int                checks = 0;
  int                failures = 0;
  int                xfers = 0;

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [WORD_W-1:0] make_word(input int w, input int base);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int p = 0; p < DEPTH_NB; p++) r[p*IMG_WIDTH +: IMG_WIDTH] = 16'(base + w*16 + p);
    return r;
  endfunction

  // Output monitor: scoreboard compare on transfers, stability while stalled.
  logic             prev_stall = 1'b0;
  logic [GRP_W-1:0] prev_bus;
  logic             prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_val", image_val, 1'b1);
        check("stall_bus", image_bus, prev_bus);
        check("stall_last", image_last, prev_last);
      end
      if (image_last) check("last_without_val", image_val, 1'b1);
      if (image_val && image_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_group actual=%0h required=none", image_bus);
        end else begin
          e = sb_q.pop_front();
          check("group_data", image_bus, e.data);
          check("group_last", image_last, e.last);
        end
        xfers++;
        prev_stall = 1'b0;
      end else if (image_val) begin
        prev_stall = 1'b1;
        prev_bus   = image_bus;
        prev_last  = image_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic cfg_write(input logic [4:0] addr, input int data);
    cfg_addr  = addr;
    cfg_data  = CFG_DWIDTH'(data);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic do_write(input int bank, input int len, input int base);
    logic [WORD_W-1:0] word;
    logic              acc;
    int                cyc;
    cfg_write(CFG_IMG_WR_LEN, len);
    cfg_write(CFG_IMG_WR, bank);
    check("wr_rdy_after_start", str_img_rdy, 1'b1);
    for (int w = 0; w < len; w++) begin
      word        = make_word(w, base);
      str_img_bus = word;
      str_img_val = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 50) begin
        @(negedge clk);
        acc = str_img_rdy;
        @(posedge clk); #1;
        cyc++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL wr_accept_timeout actual=no_accept required=accept word=%0d", w);
        break;
      end
      model_mem[bank][w % BANK_WORDS] = word;
    end
    str_img_val = 1'b0;
    check("wr_rdy_after_pass", str_img_rdy, 1'b0);
  endtask

  task automatic push_read(input int bank, input int len);
    exp_t x;
    int   a;
    logic [WORD_W-1:0] word;
    for (int g = 0; g < len; g++) begin
      a      = g % BANK_GROUPS;
      word   = model_mem[bank][a / R];
      x.data = word[(a % R)*GRP_W +: GRP_W];
      x.last = (g == len - 1);
      sb_q.push_back(x);
    end
  endtask

  task automatic drain(input int mode, input int budget);
    int cyc = 0;
    while (sb_q.size() != 0 && cyc < budget) begin
      image_rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0_pending", sb_q.size());
      sb_q.delete();
    end
    image_rdy = 1'b1;
  endtask

  task automatic run_read(input int bank, input int len, input int mode);
    cfg_write(CFG_IMG_RD_LEN, len);
    push_read(bank, len);
    cfg_write(CFG_IMG_RD, bank);
    drain(mode, len * 4 + 60);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   x0;
    int   vcnt;
    logic [WORD_W-1:0] word;

    vecs[0] = '{0, 2,   'h0000, 0, 8,    0, 8};
    vecs[1] = '{1, 3,   'h1000, 0, 8,    0, 8};
    vecs[2] = '{1, 0,   0,      1, 12,   0, 12};
    vecs[3] = '{0, 0,   0,      0, 8,    1, 8};
    vecs[4] = '{1, 258, 'h4000, 1, 1030, 0, 1030};

    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    str_img_val = 1'b0; str_img_bus = '0; image_rdy = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < BANK_WORDS; w++) model_mem[b][w] = '0;
    #12;
    check("rst_str_img_rdy", str_img_rdy, 1'b0);
    check("rst_image_val", image_val, 1'b0);
    check("rst_image_last", image_last, 1'b0);
    check("rst_image_bus", image_bus, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr_len > 0) do_write(vecs[i].wr_bank, vecs[i].wr_len, vecs[i].base);
      x0 = xfers;
      run_read(vecs[i].rd_bank, vecs[i].rd_len, vecs[i].rdy_mode);
      check($sformatf("vec%0d_xfers", i), xfers - x0, vecs[i].exp_xfers);
    end

    // Latency and back-to-back throughput.
    image_rdy = 1'b1;
    x0 = xfers;
    cfg_write(CFG_IMG_RD_LEN, 8);
    push_read(0, 8);
    cfg_write(CFG_IMG_RD, 0);
    check("lat_edge0_val", image_val, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) check("lat_edge3_val", image_val, 1'b0);
      if (k == 4) check("lat_edge4_val", image_val, 1'b1);
    end
    vcnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (image_val) vcnt++;
    end
    check("throughput_run", vcnt, 7);
    drain(0, 40);
    check("lat_xfers", xfers - x0, 8);

    // Start while busy is ignored; then length persists into the next pass.
    image_rdy = 1'b0;
    x0 = xfers;
    cfg_write(CFG_IMG_RD_LEN, 8);
    push_read(0, 8);
    cfg_write(CFG_IMG_RD, 0);
    repeat (6) begin @(posedge clk); #1; end
    cfg_write(CFG_IMG_RD, 1);
    drain(0, 60);
    check("busy_start_xfers", xfers - x0, 8);
    repeat (5) begin @(posedge clk); #1; end
    check("idle_after_pass", image_val, 1'b0);
    x0 = xfers;
    push_read(0, 8);
    cfg_write(CFG_IMG_RD, 0);
    drain(1, 100);
    check("persist_len_xfers", xfers - x0, 8);

    // Reset mid-write.
    cfg_write(CFG_IMG_WR_LEN, 4);
    cfg_write(CFG_IMG_WR, 0);
    word = make_word(0, 'h5000);
    str_img_bus = word;
    str_img_val = 1'b1;
    @(posedge clk);
    model_mem[0][0] = word;
    #3 rst = 1'b1;
    #1;
    check("rst_mid_wr_rdy", str_img_rdy, 1'b0);
    str_img_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-read.
    image_rdy = 1'b0;
    cfg_write(CFG_IMG_RD_LEN, 8);
    push_read(0, 8);
    cfg_write(CFG_IMG_RD, 0);
    repeat (6) begin @(posedge clk); #1; end
    check("pre_rst_rd_val", image_val, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rd_val", image_val, 1'b0);
    check("rst_mid_rd_last", image_last, 1'b0);
    check("rst_mid_rd_bus", image_bus, '0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Lengths were cleared by reset: starts are no-ops.
    image_rdy = 1'b1;
    cfg_write(CFG_IMG_RD, 0);
    vcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (image_val) vcnt++;
    end
    check("len0_rd_no_val", vcnt, 0);
    cfg_write(CFG_IMG_WR, 0);
    check("len0_wr_no_rdy", str_img_rdy, 1'b0);

    // Normal operation after reset; word 1 of bank 0 survives from before.
    do_write(0, 1, 'h7000);
    x0 = xfers;
    run_read(0, 8, 1);
    check("post_rst_xfers", xfers - x0, 8);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
